// File: rtl/ibex_register_file_mp_if.sv
// Bundled read/write/clear signals of the multi-port register file.
// master = pipeline side (decode/writeback), slave = register file.
interface ibex_register_file_mp_if #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned NumRdPorts = 2,
    parameter int unsigned NumWrPorts = 2
);
    logic [5*NumRdPorts-1:0]         raddr_i;
    logic [DataWidth*NumRdPorts-1:0] rdata_o;
    logic [5*NumWrPorts-1:0]         waddr_i;
    logic [DataWidth*NumWrPorts-1:0] wdata_i;
    logic [NumWrPorts-1:0]           we_i;
    logic                            clear_req_i;
    logic                            clear_busy_o;
    logic                            clear_done_o;
    logic                            wr_conflict_o;

    modport master (
        output raddr_i, waddr_i, wdata_i, we_i, clear_req_i,
        input  rdata_o, clear_busy_o, clear_done_o, wr_conflict_o
    );

    modport slave (
        input  raddr_i, waddr_i, wdata_i, we_i, clear_req_i,
        output rdata_o, clear_busy_o, clear_done_o, wr_conflict_o
    );
endinterface

// File: rtl/ibex_register_file_mp.sv
// Flip-flop register file, parametrised read/write ports, sequenced bulk clear.
// Optional write-to-read forwarding enabled by defining RF_WRITE_FWD_EN.
module ibex_register_file_mp #(
    parameter bit          RV32E      = 1'b0,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned NumRdPorts = 2,
    parameter int unsigned NumWrPorts = 2
) (
    input logic                   clk_int,
    input logic                   rst_ni,
    ibex_register_file_mp_if.slave rf
);
    localparam int unsigned AddrWidth = RV32E ? 4 : 5;
    localparam int unsigned NumWords  = 1 << AddrWidth;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [AddrWidth-1:0]       cnt_q, cnt_d;
    logic                       conflict_q, conflict_d;
    logic [DataWidth-1:0]       mem_q [NumWords];
    logic [DataWidth-1:0]       mem_d [NumWords];
    logic [DataWidth*NumRdPorts-1:0] rdata;
    logic                       clearing;

    assign clearing = (state_q == CLEAR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rf.clear_req_i) begin
                    state_d = CLEAR;
                    cnt_d   = AddrWidth'(1);
                end
            end
            CLEAR: begin
                if (cnt_q == AddrWidth'(NumWords - 1)) state_d = DONE;
                else                                   cnt_d   = cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Later write ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        for (int unsigned w = 0; w < NumWords; w++) begin
            mem_d[w] = mem_q[w];
            if (w == 0) begin
                mem_d[w] = '0;
            end else if (clearing) begin
                if (cnt_q == AddrWidth'(w)) mem_d[w] = '0;
            end else begin
                for (int unsigned q = 0; q < NumWrPorts; q++) begin
                    if (rf.we_i[q] && (rf.waddr_i[5*q +: AddrWidth] == AddrWidth'(w))) begin
                        mem_d[w] = rf.wdata_i[DataWidth*q +: DataWidth];
                    end
                end
            end
        end
    end

    always_comb begin
        conflict_d = 1'b0;
        if (!clearing) begin
            for (int unsigned a = 0; a < NumWrPorts; a++) begin
                for (int unsigned b = a + 1; b < NumWrPorts; b++) begin
                    if (rf.we_i[a] && rf.we_i[b] &&
                        (rf.waddr_i[5*a +: AddrWidth] == rf.waddr_i[5*b +: AddrWidth]) &&
                        (rf.waddr_i[5*a +: AddrWidth] != '0)) begin
                        conflict_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            conflict_q <= 1'b0;
            for (int unsigned w = 0; w < NumWords; w++) mem_q[w] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            conflict_q <= conflict_d;
            for (int unsigned w = 0; w < NumWords; w++) mem_q[w] <= mem_d[w];
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned p = 0; p < NumRdPorts; p++) begin
            rdata[DataWidth*p +: DataWidth] = mem_q[rf.raddr_i[5*p +: AddrWidth]];
`ifdef RF_WRITE_FWD_EN
            for (int unsigned q = 0; q < NumWrPorts; q++) begin
                if (rf.we_i[q] && !clearing &&
                    (rf.waddr_i[5*q +: AddrWidth] == rf.raddr_i[5*p +: AddrWidth])) begin
                    rdata[DataWidth*p +: DataWidth] = rf.wdata_i[DataWidth*q +: DataWidth];
                end
            end
`endif
            if (!rst_ni || (rf.raddr_i[5*p +: AddrWidth] == '0)) begin
                rdata[DataWidth*p +: DataWidth] = '0;
            end
        end
    end

    assign rf.rdata_o       = rdata;
    assign rf.clear_busy_o  = clearing;
    assign rf.clear_done_o  = (state_q == DONE);
    assign rf.wr_conflict_o = conflict_q;

    // Address bits above AddrWidth are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rf.raddr_i, rf.waddr_i};
endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Directed, table-driven bench for ibex_register_file_mp (RV32I and RV32E instances).
module tb_ibex_register_file_mp;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef RF_WRITE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    ibex_register_file_mp_if #(.DataWidth(32), .NumRdPorts(2), .NumWrPorts(2)) bus ();
    ibex_register_file_mp_if #(.DataWidth(32), .NumRdPorts(2), .NumWrPorts(2)) bus_e ();

    ibex_register_file_mp #(.RV32E(1'b0), .DataWidth(32), .NumRdPorts(2), .NumWrPorts(2)) dut (
        .clk_int(clk), .rst_ni(rst_n), .rf(bus));
    ibex_register_file_mp #(.RV32E(1'b1), .DataWidth(32), .NumRdPorts(2), .NumWrPorts(2)) dut_e (
        .clk_int(clk), .rst_ni(rst_n), .rf(bus_e));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit e, input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1);
        if (e) begin
            bus_e.we_i = we; bus_e.waddr_i = {wa1, wa0}; bus_e.wdata_i = {wd1, wd0};
        end else begin
            bus.we_i = we; bus.waddr_i = {wa1, wa0}; bus.wdata_i = {wd1, wd0};
        end
    endtask

    task automatic rd(input bit e, input logic [4:0] ra0, input logic [4:0] ra1);
        if (e) bus_e.raddr_i = {ra1, ra0};
        else   bus.raddr_i   = {ra1, ra0};
    endtask

    // Pulses clear_req, counts busy cycles and checks the done pulse that follows.
    task automatic run_clear(input bit e, input int busy_exp, input string tag);
        int nb = 0;
        bit conf_seen = 1'b0;
        bit fin = 1'b0;
        logic busy, done, conf;
        step();
        if (e) bus_e.clear_req_i = 1'b1; else bus.clear_req_i = 1'b1;
        step();
        bus_e.clear_req_i = 1'b0;
        bus.clear_req_i   = 1'b0;
        for (int i = 0; i < 100 && !fin; i++) begin
            @(negedge clk);
            busy = e ? bus_e.clear_busy_o  : bus.clear_busy_o;
            done = e ? bus_e.clear_done_o  : bus.clear_done_o;
            conf = e ? bus_e.wr_conflict_o : bus.wr_conflict_o;
            if (busy) begin
                nb++;
                conf_seen |= conf;
                if (!e) begin
                    if (nb == 10) drv(0, 2'b11, 5'd2, 32'h66, 5'd2, 32'h67);
                    else          drv(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
                end
            end else begin
                fin = 1'b1;
                chk({tag, " done pulse"}, {31'b0, done}, 32'd1);
            end
        end
        chk({tag, " busy cycles"}, nb, busy_exp);
        chk({tag, " no conflict while busy"}, {31'b0, conf_seen}, 32'd0);
        @(negedge clk);
        chk({tag, " done single cycle"}, {31'b0, e ? bus_e.clear_done_o : bus.clear_done_o}, 32'd0);
        chk({tag, " idle after done"}, {31'b0, e ? bus_e.clear_busy_o : bus.clear_busy_o}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        ec;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int nb;
        vecs[0]  = '{2'b01, 5'd3,  32'h33,       5'd0, 32'h0,  5'd3,  5'd4, 32'h0,        32'h0,  1'b0};
        vecs[1]  = '{2'b10, 5'd0,  32'h0,        5'd4, 32'h44, 5'd3,  5'd4, 32'h33,       32'h0,  1'b0};
        vecs[2]  = '{2'b11, 5'd5,  32'h11,       5'd5, 32'h22, 5'd3,  5'd4, 32'h33,       32'h44, 1'b0};
        vecs[3]  = '{2'b00, 5'd0,  32'h0,        5'd0, 32'h0,  5'd5,  5'd0, 32'h22,       32'h0,  1'b1};
        vecs[4]  = '{2'b11, 5'd0,  32'h1,        5'd0, 32'h2,  5'd5,  5'd3, 32'h22,       32'h33, 1'b0};
        vecs[5]  = '{2'b00, 5'd0,  32'h0,        5'd0, 32'h0,  5'd0,  5'd5, 32'h0,        32'h22, 1'b0};
        vecs[6]  = '{2'b01, 5'd0,  32'hDEADBEEF, 5'd0, 32'h0,  5'd4,  5'd3, 32'h44,       32'h33, 1'b0};
        vecs[7]  = '{2'b00, 5'd0,  32'h0,        5'd0, 32'h0,  5'd0,  5'd0, 32'h0,        32'h0,  1'b0};
        vecs[8]  = '{2'b11, 5'd7,  32'h70,       5'd8, 32'h80, 5'd31, 5'd1, 32'h0,        32'h0,  1'b0};
        vecs[9]  = '{2'b00, 5'd0,  32'h0,        5'd0, 32'h0,  5'd7,  5'd8, 32'h70,       32'h80, 1'b0};
        vecs[10] = '{2'b11, 5'd31, 32'hFFFFFFFF, 5'd1, 32'h1,  5'd7,  5'd8, 32'h70,       32'h80, 1'b0};
        vecs[11] = '{2'b00, 5'd0,  32'h0,        5'd0, 32'h0,  5'd31, 5'd1, 32'hFFFFFFFF, 32'h1,  1'b0};

        drv(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        drv(1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(0, 5'd0, 5'd0);
        rd(1, 5'd0, 5'd0);
        bus.clear_req_i   = 1'b0;
        bus_e.clear_req_i = 1'b0;

        // Reset state
        #2;
        chk("reset busy", {31'b0, bus.clear_busy_o}, 32'd0);
        chk("reset done", {31'b0, bus.clear_done_o}, 32'd0);
        chk("reset conflict", {31'b0, bus.wr_conflict_o}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            rd(0, 5'(a), 5'(31 - a));
            #1;
            chk("reset read p0", bus.rdata_o[31:0], 32'h0);
            chk("reset read p1", bus.rdata_o[63:32], 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Write to word 0 is discarded
        step();
        drv(0, 2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0);
        step();
        drv(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(0, 5'd0, 5'd0);
        #1;
        chk("addr0 after write", bus.rdata_o[31:0], 32'h0);

        // Table-driven write/read/conflict vectors
        for (int i = 0; i < 12; i++) begin
            step();
            drv(0, vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1);
            rd(0, vecs[i].ra0, vecs[i].ra1);
            @(negedge clk);
            chk($sformatf("vec%0d rdata0", i), bus.rdata_o[31:0], vecs[i].e0);
            chk($sformatf("vec%0d rdata1", i), bus.rdata_o[63:32], vecs[i].e1);
            chk($sformatf("vec%0d conflict", i), {31'b0, bus.wr_conflict_o}, {31'b0, vecs[i].ec});
        end
        step();
        drv(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

        // Fill then bulk clear; write issued mid-clear must be dropped
        for (int a = 1; a < 32; a++) begin
            step();
            drv(0, 2'b01, 5'(a), 32'hA5A5A5A5, 5'd0, 32'h0);
        end
        step();
        drv(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(0, 5'd17, 5'd31);
        #1;
        chk("filled word 17", bus.rdata_o[31:0], 32'hA5A5A5A5);
        run_clear(0, 31, "clear32");
        for (int a = 0; a < 32; a++) begin
            rd(0, 5'(a), 5'(31 - a));
            #1;
            chk($sformatf("cleared p0 a%0d", a), bus.rdata_o[31:0], 32'h0);
            chk($sformatf("cleared p1 a%0d", 31 - a), bus.rdata_o[63:32], 32'h0);
        end

        // RV32E: bit 4 ignored, 16-word clear
        step();
        drv(1, 2'b01, 5'd17, 32'h5, 5'd0, 32'h0);
        step();
        drv(1, 2'b01, 5'd16, 32'h99, 5'd0, 32'h0);
        step();
        drv(1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(1, 5'd1, 5'd17);
        #1;
        chk("rv32e read 1", bus_e.rdata_o[31:0], 32'h5);
        chk("rv32e read 17", bus_e.rdata_o[63:32], 32'h5);
        rd(1, 5'd16, 5'd0);
        #1;
        chk("rv32e addr16 is zero", bus_e.rdata_o[31:0], 32'h0);
        run_clear(1, 15, "clear16");
        rd(1, 5'd1, 5'd17);
        #1;
        chk("rv32e cleared 1", bus_e.rdata_o[31:0], 32'h0);

        // Same-cycle write/read, with and without forwarding
        step();
        drv(0, 2'b01, 5'd9, 32'h10, 5'd0, 32'h0);
        step();
        drv(0, 2'b01, 5'd9, 32'h77, 5'd0, 32'h0);
        rd(0, 5'd9, 5'd9);
        @(negedge clk);
        chk("fwd same cycle", bus.rdata_o[31:0], FWD ? 32'h77 : 32'h10);
        step();
        drv(0, 2'b11, 5'd9, 32'h88, 5'd9, 32'h99);
        @(negedge clk);
        chk("fwd next cycle", bus.rdata_o[63:32], FWD ? 32'h99 : 32'h77);
        step();
        drv(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        @(negedge clk);
        chk("dual write priority", bus.rdata_o[31:0], 32'h99);
        chk("dual write conflict", {31'b0, bus.wr_conflict_o}, 32'd1);
        step();
        chk("conflict single cycle", {31'b0, bus.wr_conflict_o}, 32'd0);

        // Reset in the middle of a clear
        drv(0, 2'b01, 5'd12, 32'hAB, 5'd0, 32'h0);
        step();
        drv(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        bus.clear_req_i = 1'b1;
        step();
        bus.clear_req_i = 1'b0;
        nb = 0;
        for (int i = 0; i < 100 && nb < 10; i++) begin
            @(negedge clk);
            if (bus.clear_busy_o) nb++;
        end
        chk("reached clear cycle 10", nb, 10);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid-clear reset busy", {31'b0, bus.clear_busy_o}, 32'd0);
        chk("mid-clear reset done", {31'b0, bus.clear_done_o}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            rd(0, 5'(a), 5'(31 - a));
            #1;
            chk($sformatf("mid-clear reset a%0d", a), bus.rdata_o[31:0], 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle after reset busy", {31'b0, bus.clear_busy_o}, 32'd0);
        step();
        drv(0, 2'b01, 5'd12, 32'h5A, 5'd0, 32'h0);
        step();
        drv(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd(0, 5'd12, 5'd0);
        #1;
        chk("write after reset", bus.rdata_o[31:0], 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
